// File: rtl/tw_rom_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tw_rom_seq_ctrl
//
// Loader and run sequencer for the 128-bit twiddle ROM (TW_ROM3 family) used
// by the radix-16 BFFTP datapath.
//
// Load path: the host pushes 2*LOAD_ENTRIES 64-bit words over a valid/ready
// port. Words 0..LOAD_ENTRIES-1 are the high halves of ROM entries
// 0..LOAD_ENTRIES-1, and the remaining words are the matching low halves.
// Once the buffer is full, the words are burst into the ROM's stage-0 table:
// the high halves go first (ROM3_w=1), then one idle cycle resets the ROM's
// entry index, then the low halves follow (ROM3_w=2).
//
// Run path: start walks stage_counter through STAGE_NUM stages. Each stage
// holds CEN low for STAGE_LEN cycles with state=RUN_STATE. A single CEN-high
// gap cycle separates consecutive stages. The run ends with a one-cycle done
// pulse.
//
// Optional build macro: TW_SEQ_ABORT_EN adds an 'abort' input. Asserting it
// during RUN or GAP drops the run and returns to IDLE without pulsing done.
//
// Ports:
//   CLK                  clock, rising edge
//   rst                  asynchronous reset, active-high
//   start                single-cycle run request, honoured only in IDLE
//   abort                (TW_SEQ_ABORT_EN only) cancel an active run
//   ld_valid / ld_data   host word and its valid strobe
//   ld_ready             high in IDLE and COLLECT
//   busy                 high whenever the FSM is not IDLE
//   done                 one-cycle pulse at the end of a completed run
//   ROM3_w               ROM write select: 1 = high half, 2 = low half, 0 = none
//   horizontal_data_out  ROM write data
//   CEN                  ROM enable, active-low
//   stage_counter        current FFT stage
//   state                ROM run-state code
// -----------------------------------------------------------------------------
module tw_rom_seq_ctrl #(
  parameter int SC_WIDTH     = 3,
  parameter int S_WIDTH      = 4,
  parameter int HDW          = 64,
  parameter int LOAD_ENTRIES = 4,
  parameter int STAGE_NUM    = 3,
  parameter int STAGE_LEN    = 256,
  parameter int RUN_STATE    = 4
) (
  input  logic                CLK,
  input  logic                rst,
  input  logic                start,
`ifdef TW_SEQ_ABORT_EN
  input  logic                abort,
`endif
  input  logic                ld_valid,
  input  logic [HDW-1:0]      ld_data,
  output logic                ld_ready,
  output logic                busy,
  output logic                done,
  output logic [1:0]          ROM3_w,
  output logic [HDW-1:0]      horizontal_data_out,
  output logic                CEN,
  output logic [SC_WIDTH-1:0] stage_counter,
  output logic [S_WIDTH-1:0]  state
);

  localparam int NWORDS = 2 * LOAD_ENTRIES;
  localparam int AW     = $clog2(NWORDS);
  localparam int CW     = (STAGE_LEN > 1) ? $clog2(STAGE_LEN) : 1;

  localparam logic [AW-1:0]       LAST_WORD  = AW'(NWORDS - 1);
  localparam logic [AW-1:0]       LO_BASE    = AW'(LOAD_ENTRIES);
  localparam logic [CW-1:0]       LAST_CYC   = CW'(STAGE_LEN - 1);
  localparam logic [SC_WIDTH-1:0] LAST_STAGE = SC_WIDTH'(STAGE_NUM - 1);
  localparam logic [S_WIDTH-1:0]  STATE_RUN  = S_WIDTH'(RUN_STATE);

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    BURST_HI,
    BURST_GAP,
    BURST_LO,
    RUN,
    GAP,
    DONE
  } fsm_t;

  fsm_t           fsm;
  logic [HDW-1:0] word_buf [NWORDS];
  // This index is shared by COLLECT (the next word to store) and the two
  // burst phases (the next entry to drive). It never exceeds NWORDS-1.
  logic [AW-1:0]  widx;
  logic [CW-1:0]  cyc;
  logic           abort_req;

`ifdef TW_SEQ_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  // ld_ready is held low while rst is asserted, even though the FSM already
  // sits in IDLE at that point.
  assign ld_ready = !rst && ((fsm == IDLE) || (fsm == COLLECT));
  assign busy     = (fsm != IDLE);

  // NOTE: all state below uses non-blocking assignments. Every register then
  // updates from the pre-edge values, which keeps the FSM free of races.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      fsm                 <= IDLE;
      widx                <= '0;
      cyc                 <= '0;
      ROM3_w              <= 2'd0;
      horizontal_data_out <= '0;
      CEN                 <= 1'b1;
      stage_counter       <= '0;
      state               <= '0;
      done                <= 1'b0;
      // NOTE: the word buffer is deliberately cleared on reset. A reset during
      // a load must discard any partially collected words. Storage that
      // needs no such guarantee would normally be left unreset.
      for (int i = 0; i < NWORDS; i++) word_buf[i] <= '0;
    end else begin
      done <= 1'b0;
      case (fsm)
        IDLE: begin
          // When a load beat and start arrive together, the load wins.
          if (ld_valid && ld_ready) begin
            word_buf[0] <= ld_data;
            widx        <= AW'(1);
            fsm         <= COLLECT;
          end else if (start) begin
            fsm           <= RUN;
            cyc           <= '0;
            CEN           <= 1'b0;
            stage_counter <= '0;
            state         <= STATE_RUN;
          end
        end

        COLLECT: begin
          if (ld_valid && ld_ready) begin
            word_buf[widx] <= ld_data;
            if (widx == LAST_WORD) begin
              // Drive the first high half in the same cycle the burst
              // begins, so ROM3_w and the data line up with BURST_HI.
              fsm                 <= BURST_HI;
              ROM3_w              <= 2'd1;
              horizontal_data_out <= word_buf[0];
              widx                <= AW'(1);
            end else begin
              widx <= widx + AW'(1);
            end
          end
        end

        BURST_HI: begin
          if (widx == LO_BASE) begin
            fsm    <= BURST_GAP;
            ROM3_w <= 2'd0;
            widx   <= '0;
          end else begin
            horizontal_data_out <= word_buf[widx];
            widx                <= widx + AW'(1);
          end
        end

        BURST_GAP: begin
          // One idle write cycle rewinds the ROM's internal entry index
          // before the low halves are written.
          fsm                 <= BURST_LO;
          ROM3_w              <= 2'd2;
          horizontal_data_out <= word_buf[LO_BASE];
          widx                <= AW'(1);
        end

        BURST_LO: begin
          if (widx == LO_BASE) begin
            fsm    <= IDLE;
            ROM3_w <= 2'd0;
            widx   <= '0;
          end else begin
            horizontal_data_out <= word_buf[LO_BASE + widx];
            widx                <= widx + AW'(1);
          end
        end

        RUN: begin
          if (abort_req) begin
            fsm           <= IDLE;
            cyc           <= '0;
            CEN           <= 1'b1;
            state         <= '0;
            stage_counter <= '0;
          end else if (cyc == LAST_CYC) begin
            cyc   <= '0;
            CEN   <= 1'b1;
            state <= '0;
            if (stage_counter == LAST_STAGE) begin
              // The last stage is not followed by a gap cycle.
              fsm           <= DONE;
              done          <= 1'b1;
              stage_counter <= '0;
            end else begin
              fsm <= GAP;
            end
          end else begin
            cyc <= cyc + CW'(1);
          end
        end

        GAP: begin
          if (abort_req) begin
            fsm           <= IDLE;
            cyc           <= '0;
            CEN           <= 1'b1;
            state         <= '0;
            stage_counter <= '0;
          end else begin
            fsm           <= RUN;
            CEN           <= 1'b0;
            state         <= STATE_RUN;
            stage_counter <= stage_counter + SC_WIDTH'(1);
          end
        end

        DONE: fsm <= IDLE;

        default: fsm <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tw_rom_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_tw_rom_seq_ctrl
//
// Self-checking bench for tw_rom_seq_ctrl. The bench shortens STAGE_LEN to 16
// so that a full run takes 51 cycles.
//
// Expected values come from a reference model written straight from the
// block's rules:
//   - Loads: a queue of the words the host actually handed over. The burst
//     is expected to replay that queue as high halves, one gap cycle, then
//     low halves.
//   - Runs: cycle k after start is decoded arithmetically into a stage number
//     and a position within that stage.
//
// Inputs are driven on the falling edge and outputs are sampled on the
// falling edge.
// -----------------------------------------------------------------------------
module tb_tw_rom_seq_ctrl;

  localparam int SC_WIDTH     = 3;
  localparam int S_WIDTH      = 4;
  localparam int HDW          = 64;
  localparam int LOAD_ENTRIES = 4;
  localparam int STAGE_NUM    = 3;
  localparam int STAGE_LEN    = 16;
  localparam int RUN_STATE    = 4;

  localparam int NW         = 2 * LOAD_ENTRIES;
  localparam int BURST_LEN  = NW + 1;
  localparam int RUN_CYCLES = STAGE_NUM * STAGE_LEN + (STAGE_NUM - 1) + 1;
  localparam int NO_CUT     = 1000;

  logic                CLK = 1'b0;
  logic                rst = 1'b1;
  logic                start = 1'b0;
  logic                ld_valid = 1'b0;
  logic [HDW-1:0]      ld_data = '0;
  logic                ld_ready;
  logic                busy;
  logic                done;
  logic [1:0]          ROM3_w;
  logic [HDW-1:0]      horizontal_data_out;
  logic                CEN;
  logic [SC_WIDTH-1:0] stage_counter;
  logic [S_WIDTH-1:0]  state;
`ifdef TW_SEQ_ABORT_EN
  logic                abort = 1'b0;
`endif

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  tw_rom_seq_ctrl #(
    .SC_WIDTH    (SC_WIDTH),
    .S_WIDTH     (S_WIDTH),
    .HDW         (HDW),
    .LOAD_ENTRIES(LOAD_ENTRIES),
    .STAGE_NUM   (STAGE_NUM),
    .STAGE_LEN   (STAGE_LEN),
    .RUN_STATE   (RUN_STATE)
  ) dut (
    .CLK                (CLK),
    .rst                (rst),
    .start              (start),
`ifdef TW_SEQ_ABORT_EN
    .abort              (abort),
`endif
    .ld_valid           (ld_valid),
    .ld_data            (ld_data),
    .ld_ready           (ld_ready),
    .busy               (busy),
    .done               (done),
    .ROM3_w             (ROM3_w),
    .horizontal_data_out(horizontal_data_out),
    .CEN                (CEN),
    .stage_counter      (stage_counter),
    .state              (state)
  );

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Returns the expected {CEN, stage_counter, state, done, busy} for cycle k
  // after the start edge. Any cycle after 'cut' is expected to be idle.
  function automatic logic [9:0] run_expect(input int k, input int cut);
    int stage;
    int pos;
    if (k < 1 || k > cut || k > RUN_CYCLES) return {1'b1, 3'd0, 4'd0, 1'b0, 1'b0};
    if (k == RUN_CYCLES) return {1'b1, 3'd0, 4'd0, 1'b1, 1'b1};
    stage = (k - 1) / (STAGE_LEN + 1);
    pos   = (k - 1) % (STAGE_LEN + 1);
    if (pos < STAGE_LEN) return {1'b0, 3'(stage), 4'(RUN_STATE), 1'b0, 1'b1};
    return {1'b1, 3'(stage), 4'd0, 1'b0, 1'b1};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    ld_valid = 1'b0;
    repeat (2) @(negedge CLK);
    checks++;
    if ({ROM3_w, CEN, stage_counter, state, busy, done, ld_ready} !== {2'd0, 1'b1, 3'd0, 4'd0, 3'b000}) begin
      errors++;
      $display("FAIL reset_ctrl got=%b exp=%b",
               {ROM3_w, CEN, stage_counter, state, busy, done, ld_ready}, {2'd0, 1'b1, 3'd0, 4'd0, 3'b000});
    end
    checks++;
    if (horizontal_data_out !== '0) begin
      errors++;
      $display("FAIL reset_data got=%h exp=0", horizontal_data_out);
    end
    rst = 1'b0;
    @(negedge CLK);
    checks++;
    if ({ld_ready, busy, CEN} !== 3'b101) begin
      errors++;
      $display("FAIL reset_release got={ld_ready,busy,CEN}=%b exp=101", {ld_ready, busy, CEN});
    end
  endtask

  // mode 0: continuous valid; 1: valid every other cycle; 2: random valid.
  // seq_words selects data 1..8 instead of random words. start is asserted on
  // the first beat and is toggled randomly through collect and burst; it must
  // never launch a run.
  task automatic test_load(input string name, input int mode, input bit seq_words);
    logic [HDW-1:0] words[$];
    logic [HDW-1:0] w;
    logic [1:0]     exp_w;
    logic [HDW-1:0] exp_d;
    bit             v;
    int             acc;
    int             cyc;
    acc = 0;
    cyc = 0;
    while (acc < NW) begin
      if (cyc > 200) begin
        errors++;
        $display("FAIL %s load_timeout accepted=%0d exp=%0d", name, acc, NW);
        break;
      end
      v = (acc == 0) || (mode == 0) || (mode == 1 && (cyc % 2 == 0)) ||
          (mode == 2 && $urandom_range(0, 1) == 1);
      w = seq_words ? HDW'(acc + 1) : {$urandom, $urandom};
      ld_valid = v;
      ld_data  = v ? w : {$urandom, $urandom};
      start    = (acc == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      checks++;
      if ({ld_ready, ROM3_w, CEN, busy} !== {1'b1, 2'd0, 1'b1, (acc > 0)}) begin
        errors++;
        $display("FAIL %s collect cyc=%0d got={ready,w,CEN,busy}=%b exp=%b", name, cyc,
                 {ld_ready, ROM3_w, CEN, busy}, {1'b1, 2'd0, 1'b1, (acc > 0)});
      end
      if (v) begin
        words.push_back(w);
        acc++;
      end
      cyc++;
      @(negedge CLK);
    end
    while (words.size() < NW) words.push_back('0);
    for (int b = 0; b <= BURST_LEN + 1; b++) begin
      exp_w = (b < LOAD_ENTRIES) ? 2'd1 : (b == LOAD_ENTRIES || b >= BURST_LEN) ? 2'd0 : 2'd2;
      exp_d = (b < LOAD_ENTRIES) ? words[b] : (b > LOAD_ENTRIES && b < BURST_LEN) ? words[b-1] : '0;
      checks++;
      if ({ROM3_w, ld_ready, busy, CEN} !== {exp_w, (b >= BURST_LEN), (b < BURST_LEN), 1'b1}) begin
        errors++;
        $display("FAIL %s burst b=%0d got={w,ready,busy,CEN}=%b exp=%b", name, b,
                 {ROM3_w, ld_ready, busy, CEN}, {exp_w, (b >= BURST_LEN), (b < BURST_LEN), 1'b1});
      end
      if (exp_w != 2'd0) begin
        checks++;
        if (horizontal_data_out !== exp_d) begin
          errors++;
          $display("FAIL %s burst_data b=%0d got=%h exp=%h", name, b, horizontal_data_out, exp_d);
        end
      end
      if (b < BURST_LEN - 1) begin
        ld_valid = 1'($urandom_range(0, 1));
        ld_data  = {$urandom, $urandom};
        start    = 1'($urandom_range(0, 1));
      end else begin
        ld_valid = 1'b0;
        start    = 1'b0;
      end
      @(negedge CLK);
    end
  endtask

  // Runs one start pulse and checks every cycle against the model. At cycle
  // 'cut', it either asserts rst (use_rst) or abort; NO_CUT lets the run
  // complete.
  task automatic test_run(input string name, input int cut, input bit use_rst);
    logic [9:0] got;
    logic [9:0] exp;
    repeat ($urandom_range(0, 3)) @(negedge CLK);
    ld_valid = 1'b0;
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    for (int k = 1; k <= RUN_CYCLES + 2; k++) begin
      got = {CEN, stage_counter, state, done, busy};
      exp = run_expect(k, cut);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL %s k=%0d got={CEN,sc,state,done,busy}=%b exp=%b", name, k, got, exp);
      end
      if (k == cut) begin
        if (use_rst) begin
          #1 rst = 1'b1;
          #1;
          checks++;
          if ({CEN, stage_counter, state, done, busy, ld_ready, ROM3_w} !== {1'b1, 3'd0, 4'd0, 5'd0}) begin
            errors++;
            $display("FAIL %s async_rst got=%b exp=%b", name,
                     {CEN, stage_counter, state, done, busy, ld_ready, ROM3_w}, {1'b1, 3'd0, 4'd0, 5'd0});
          end
        end else begin
`ifdef TW_SEQ_ABORT_EN
          abort = 1'b1;
`endif
        end
      end
      if (k == cut + 1) begin
        rst = 1'b0;
`ifdef TW_SEQ_ABORT_EN
        abort = 1'b0;
`endif
      end
      @(negedge CLK);
    end
  endtask

  initial begin
    test_reset();
    test_load("load_cont", 0, 1'b1);
    test_load("load_toggle", 1, 1'b1);
    test_load("load_rand", 2, 1'b0);
    test_load("load_b2b", 0, 1'b0);
    test_run("run_full", NO_CUT, 1'b0);
    test_run("run_b2b", NO_CUT, 1'b0);
    test_run("run_rst_mid", STAGE_LEN + 1 + 8, 1'b1);
    test_run("run_after_rst", NO_CUT, 1'b0);
    test_load("load_after_run", 2, 1'b0);
`ifdef TW_SEQ_ABORT_EN
    test_run("abort_stage2", 2 * (STAGE_LEN + 1) + 10 + 1, 1'b0);
    test_run("abort_gap", STAGE_LEN + 1, 1'b0);
    test_run("abort_rand", $urandom_range(1, RUN_CYCLES - 1), 1'b0);
    test_run("run_after_abort", NO_CUT, 1'b0);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
